tag_ram_nway: RTL and testbench

- Parametrised N-way cache tag store; successor to the single-array synchronous-read tag RAM.
- Holds one tag plus one valid bit per way, per set.
- Provides a one-cycle registered lookup with tag compare and hit/way reporting, plus a write/invalidate port.
- A reset- or command-triggered flush engine clears all valid bits. Sits between the cache controller and the data RAMs.

---
 rtl/tag_ram_nway.sv | 148 ++++++++++++++
 tb/tb_tag_ram_nway.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/tag_ram_nway.sv
// tag_ram_nway: parametrised N-way cache tag store.
//   Keeps one tag and one valid bit per way for each set. A lookup is
//   registered and returns the set's tags, its valid bits and a per-way
//   hit vector one cycle later. A write port stores or invalidates the
//   selected ways. A flush engine, started by reset or by a flush pulse,
//   clears the valid bits one set per cycle and deasserts ready while it
//   runs.
// Ports:
//   clock, reset                 rising-edge clock, sync active-high reset
//   flush                        pulse; starts a valid-bit flush when ready
//   ready                        idle; lookups/writes accepted only then
//   lu_en/lu_index/lu_tag        lookup request
//   wr_en/wr_index/wr_way/       write request (wr_way one-hot or multi-hot)
//   wr_tag/wr_vbit
//   hit_valid/hit/hit_way        registered lookup result
//   rd_tags/rd_vbits             registered set contents (way0 in LSBs)

// Per-way read path: write-first bypass plus tag compare.
module tag_ram_way #(
  parameter int TWIDTH = 14
) (
  input  logic [TWIDTH-1:0] st_tag,
  input  logic              st_vbit,
  input  logic              byp,
  input  logic [TWIDTH-1:0] byp_tag,
  input  logic              byp_vbit,
  input  logic [TWIDTH-1:0] lu_tag,
  output logic [TWIDTH-1:0] eff_tag,
  output logic              eff_vbit,
  output logic              match
);
  assign eff_tag  = byp ? byp_tag  : st_tag;
  assign eff_vbit = byp ? byp_vbit : st_vbit;
  assign match    = eff_vbit && (eff_tag == lu_tag);
endmodule

module tag_ram_nway #(
  parameter int AWIDTH = 3,
  parameter int TWIDTH = 14,
  parameter int WAYS   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  output logic                     ready,
  input  logic                     lu_en,
  input  logic [AWIDTH-1:0]        lu_index,
  input  logic [TWIDTH-1:0]        lu_tag,
  input  logic                     wr_en,
  input  logic [AWIDTH-1:0]        wr_index,
  input  logic [WAYS-1:0]          wr_way,
  input  logic [TWIDTH-1:0]        wr_tag,
  input  logic                     wr_vbit,
  output logic                     hit_valid,
  output logic                     hit,
  output logic [WAYS-1:0]          hit_way,
  output logic [WAYS*TWIDTH-1:0]   rd_tags,
  output logic [WAYS-1:0]          rd_vbits
);
  localparam int DEPTH = 1 << AWIDTH;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t                         state;
  logic [AWIDTH-1:0]              cnt;
  logic [WAYS-1:0][TWIDTH-1:0]    tag_mem [DEPTH];
  logic [DEPTH-1:0][WAYS-1:0]     valid;

  logic                           wr_acc, lu_acc, byp_set;
  logic [WAYS-1:0][TWIDTH-1:0]    eff_tag;
  logic [WAYS-1:0]                eff_vbit, match;
  logic [WAYS-1:0][TWIDTH-1:0]    st_tags;

  // ready is a register and may still be high in the first reset cycle,
  // so reset gates acceptance explicitly.
  assign wr_acc  = ready && wr_en && !reset;
  assign lu_acc  = ready && lu_en && !reset;
  assign byp_set = wr_acc && (wr_index == lu_index);
  assign st_tags = tag_mem[lu_index];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    tag_ram_way #(.TWIDTH(TWIDTH)) u_way (
      .st_tag   (st_tags[w]),
      .st_vbit  (valid[lu_index][w]),
      .byp      (byp_set && wr_way[w]),
      .byp_tag  (wr_tag),
      .byp_vbit (wr_vbit),
      .lu_tag   (lu_tag),
      .eff_tag  (eff_tag[w]),
      .eff_vbit (eff_vbit[w]),
      .match    (match[w])
    );
  end

  // Tag storage has no reset; contents are meaningful only once written.
  always_ff @(posedge clock) begin
    if (wr_acc) begin
      for (int w = 0; w < WAYS; w++)
        if (wr_way[w]) tag_mem[wr_index][w] <= wr_tag;
    end
  end

  // Control, valid bits and registered lookup result. Valid bits are not
  // reset directly: reset enters FLUSH, which clears them set by set.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= FLUSH;
      cnt       <= '0;
      ready     <= 1'b0;
      hit_valid <= 1'b0;
      hit       <= 1'b0;
      hit_way   <= '0;
      rd_tags   <= '0;
      rd_vbits  <= '0;
    end else begin
      hit_valid <= lu_acc;
      if (lu_acc) begin
        hit_way  <= match;
        hit      <= |match;
        rd_tags  <= eff_tag;
        rd_vbits <= eff_vbit;
      end
      case (state)
        FLUSH: begin
          valid[cnt] <= '0;
          cnt        <= cnt + 1'b1;
          if (cnt == AWIDTH'(DEPTH - 1)) begin
            state <= IDLE;
            ready <= 1'b1;
          end
        end
        default: begin
          if (wr_acc) begin
            for (int w = 0; w < WAYS; w++)
              if (wr_way[w]) valid[wr_index][w] <= wr_vbit;
          end
          // A write/lookup presented alongside flush has already been
          // taken above; the flush begins on the following cycle.
          if (flush) begin
            state <= FLUSH;
            cnt   <= '0;
            ready <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_tag_ram_nway.sv
// Self-checking bench for tag_ram_nway: directed scenarios followed by
// randomized traffic, all compared against a set/way array model.
module tb_tag_ram_nway;
  localparam int AW = 3, TW = 14, WAYS = 2;
  localparam int DEPTH = 1 << AW;

  logic              clock = 1'b0;
  logic              reset, flush, lu_en, wr_en, wr_vbit;
  logic [AW-1:0]     lu_index, wr_index;
  logic [TW-1:0]     lu_tag, wr_tag;
  logic [WAYS-1:0]   wr_way;
  logic              ready, hit_valid, hit;
  logic [WAYS-1:0]   hit_way, rd_vbits;
  logic [WAYS*TW-1:0] rd_tags;

  tag_ram_nway #(.AWIDTH(AW), .TWIDTH(TW), .WAYS(WAYS)) dut (
    .clock(clock), .reset(reset), .flush(flush), .ready(ready),
    .lu_en(lu_en), .lu_index(lu_index), .lu_tag(lu_tag),
    .wr_en(wr_en), .wr_index(wr_index), .wr_way(wr_way),
    .wr_tag(wr_tag), .wr_vbit(wr_vbit),
    .hit_valid(hit_valid), .hit(hit), .hit_way(hit_way),
    .rd_tags(rd_tags), .rd_vbits(rd_vbits)
  );

  always #5 clock = ~clock;

  // Model: per-set, per-way tag/valid plus "tag has been written" flag.
  int           n_chk = 0, n_fail = 0;
  logic [TW-1:0] mtag [DEPTH][WAYS];
  bit            mval [DEPTH][WAYS];
  bit            mknown [DEPTH][WAYS];
  int            fl_left = DEPTH;  // sets still to clear; 0 => ready
  bit            e_hv, e_hit;
  logic [WAYS-1:0] e_hw, e_vb;
  logic [TW-1:0] e_tg [WAYS];
  bit            e_tk [WAYS];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock, update the model with the inputs sampled at that
  // edge, then compare every output.
  task automatic step();
    bit rdy;
    @(posedge clock);
    if (reset) begin
      fl_left = DEPTH;
      e_hv = 0; e_hit = 0; e_hw = '0; e_vb = '0;
      for (int w = 0; w < WAYS; w++) begin e_tg[w] = '0; e_tk[w] = 1; end
    end else begin
      rdy = (fl_left == 0);
      e_hv = 0;
      if (!rdy) begin
        for (int w = 0; w < WAYS; w++) mval[DEPTH - fl_left][w] = 0;
        fl_left--;
      end else begin
        if (wr_en)
          for (int w = 0; w < WAYS; w++)
            if (wr_way[w]) begin
              mtag[wr_index][w] = wr_tag;
              mval[wr_index][w] = wr_vbit;
              mknown[wr_index][w] = 1;
            end
        if (lu_en) begin
          e_hv = 1;
          for (int w = 0; w < WAYS; w++) begin
            e_vb[w] = mval[lu_index][w];
            e_hw[w] = mval[lu_index][w] && (mtag[lu_index][w] == lu_tag);
            e_tg[w] = mtag[lu_index][w];
            e_tk[w] = mknown[lu_index][w];
          end
          e_hit = |e_hw;
        end
        if (flush) fl_left = DEPTH;
      end
    end
    #1;
    chk("ready", 64'(ready), 64'(fl_left == 0));
    chk("hit_valid", 64'(hit_valid), 64'(e_hv));
    chk("hit", 64'(hit), 64'(e_hit));
    chk("hit_way", 64'(hit_way), 64'(e_hw));
    chk("rd_vbits", 64'(rd_vbits), 64'(e_vb));
    for (int w = 0; w < WAYS; w++)
      if (e_tk[w]) chk("rd_tags", 64'(rd_tags[w*TW +: TW]), 64'(e_tg[w]));
  endtask

  task automatic idle_in();
    reset = 0; flush = 0; lu_en = 0; wr_en = 0;
  endtask

  task automatic do_wr(input int idx, input logic [WAYS-1:0] way, input logic [TW-1:0] t, input bit vb);
    wr_en = 1; wr_index = AW'(idx); wr_way = way; wr_tag = t; wr_vbit = vb;
  endtask

  task automatic do_lu(input int idx, input logic [TW-1:0] t);
    lu_en = 1; lu_index = AW'(idx); lu_tag = t;
  endtask

  initial begin
    for (int s = 0; s < DEPTH; s++)
      for (int w = 0; w < WAYS; w++) begin mval[s][w] = 0; mknown[s][w] = 0; end
    idle_in(); reset = 1;
    lu_index = '0; lu_tag = '0; wr_index = '0; wr_way = '0; wr_tag = '0; wr_vbit = 0;

    // 1: reset then flush of DEPTH cycles; lookups meanwhile are ignored.
    step(); step();
    chk("rst_ready", 64'(ready), 64'd0);
    idle_in();
    for (int i = 0; i < DEPTH; i++) begin
      do_lu(i, 14'h0);
      step();
      if (i < DEPTH - 1) chk("flush_ready_low", 64'(ready), 64'd0);
      chk("flush_no_hv", 64'(hit_valid), 64'd0);
    end
    chk("ready_after_8", 64'(ready), 64'd1);
    idle_in(); step();

    // 2: write then look up.
    do_wr(5, 2'b10, 14'h1A2B, 1); step(); idle_in();
    do_lu(5, 14'h1A2B); step(); idle_in();
    chk("t2_hit", 64'(hit), 64'd1);
    chk("t2_hit_way", 64'(hit_way), 64'h2);
    chk("t2_rd_vbits", 64'(rd_vbits), 64'h2);
    chk("t2_rd_tag1", 64'(rd_tags[27:14]), 64'h1A2B);

    // 3: same-cycle write/lookup bypass, then a miss.
    do_wr(3, 2'b01, 14'h0055, 1); do_lu(3, 14'h0055); step(); idle_in();
    chk("t3_byp_hit_way", 64'(hit_way), 64'h1);
    do_lu(3, 14'h0056); step(); idle_in();
    chk("t3_miss", 64'(hit), 64'd0);
    chk("t3_miss_hv", 64'(hit_valid), 64'd1);

    // 4: invalidate keeps the tag but clears the valid bit.
    do_wr(5, 2'b10, 14'h1A2B, 0); step(); idle_in();
    do_lu(5, 14'h1A2B); step(); idle_in();
    chk("t4_hit", 64'(hit), 64'd0);
    chk("t4_vbits", 64'(rd_vbits), 64'd0);
    chk("t4_tag", 64'(rd_tags[27:14]), 64'h1A2B);

    // 5: fill everything, flush, reset mid-flush, verify all invalid.
    for (int s = 0; s < DEPTH; s++) begin
      do_wr(s, 2'b11, TW'(s * 3 + 1), 1); step();
    end
    idle_in(); flush = 1; step(); idle_in();
    step(); step();
    reset = 1; step(); idle_in();
    for (int i = 0; i < DEPTH; i++) begin
      if (i < DEPTH - 1) begin step(); chk("t5_ready_low", 64'(ready), 64'd0); end
      else step();
    end
    chk("t5_ready", 64'(ready), 64'd1);
    for (int s = 0; s < DEPTH; s++) begin
      do_lu(s, TW'(s * 3 + 1)); step();
      chk("t5_hit", 64'(hit), 64'd0);
      chk("t5_vbits", 64'(rd_vbits), 64'd0);
    end
    idle_in();

    // 6: back-to-back lookups across all sets.
    do_wr(2, 2'b01, 14'h3FFF, 1); step(); idle_in();
    for (int s = 0; s < DEPTH; s++) begin
      do_lu(s, 14'h3FFF); step();
      chk("t6_hv", 64'(hit_valid), 64'd1);
      chk("t6_hit", 64'(hit), 64'(s == 2));
    end
    idle_in(); step();
    chk("t6_hv_drop", 64'(hit_valid), 64'd0);
    chk("t6_hold_hit", 64'(hit), 64'd0);

    // Random traffic: small tag pool so hits, bypasses and multi-hot
    // writes happen often; occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      logic [TW-1:0] pool [4];
      pool[0] = 14'h1A2B; pool[1] = 14'h0055; pool[2] = 14'h3FFF; pool[3] = 14'h0001;
      idle_in();
      wr_en = ($urandom_range(0, 1) == 1);
      wr_index = AW'($urandom_range(0, DEPTH - 1));
      wr_way = WAYS'($urandom_range(0, (1 << WAYS) - 1));
      wr_tag = pool[$urandom_range(0, 3)];
      wr_vbit = ($urandom_range(0, 3) != 0);
      lu_en = ($urandom_range(0, 3) != 0);
      lu_index = ($urandom_range(0, 2) == 0) ? wr_index : AW'($urandom_range(0, DEPTH - 1));
      lu_tag = pool[$urandom_range(0, 3)];
      flush = ($urandom_range(0, 49) == 0);
      reset = ($urandom_range(0, 149) == 0);
      step();
    end
    idle_in(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
